vp_cfg_sequencer: RTL and testbench
===================================

Name: vp_cfg_sequencer

Overview:
- Configuration controller for the video-process pipeline (cutter, filter, scaler, edger, binarizer, filler).
- Software writes CR/START/END/SCALER into shadow registers, then issues a commit.
- The block validates the staged set, holds it until the next frame start (vs rising edge), and applies it atomically.
- Asserts a mute window after a mode change so downstream never sees a torn frame.

Parameters:
- H_DISP, 1280, active pixels per line; upper bound for X fields.
- V_DISP, 720, active lines; upper bound for Y fields.
- XW, 11, X field width.
- YW, 11, Y field width.
- MUTE_FRAMES, 2, frames muted after a mode change (1..15).
- TIMEOUT_CYC, 1048576, ARMED timeout in clk cycles (optional feature only).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- cfg_wr  in  1  shadow register write strobe
- cfg_addr  in  3  0 CR, 1 START, 2 END, 3 SCALER, 4 STATUS (W1C)
- cfg_wdata  in  32  write data; X field = [XW-1:0], Y field = [YW-1+16:16], mode = CR[31:30]
- commit  in  1  one-cycle pulse requesting apply
- vs_in  in  1  frame sync, already in the clk domain, active-high
- act_mode  out  2  00 scaler, 01 edge, 10 binarizer, 11 bypass
- start_x / end_x / out_x_res  out  XW  active crop window and output width
- start_y / end_y / out_y_res  out  YW  active crop window and output height
- in_x_res_m1 / out_x_res_m1  out  XW  end_x-start_x-1 and out_x_res-1
- in_y_res_m1 / out_y_res_m1  out  YW  end_y-start_y-1 and out_y_res-1
- filler_en  out  1  (act_mode==00) && (out_x_res < H_DISP)
- mute  out  1  downstream must blank de while high
- status  out  32  [0] busy, [1] armed, [2] err (sticky), [3] mute, [4] timeout (sticky), [31:16] frame count

Behaviour:
- Reset values:
  - act_mode=11, start_x=start_y=0, end_x=H_DISP, end_y=V_DISP, out_x_res=H_DISP, out_y_res=V_DISP.
  - Derived *_m1 outputs follow these values; filler_en=0; mute=0.
  - status=0, shadow registers hold the same defaults, state IDLE.
- Edge detect and frame count:
  - vs_d is registered from vs_in; vs_rise = vs_in & ~vs_d.
  - The frame count increments on every vs_rise and wraps at 16 bits.
- Shadow writes:
  - Accepted in any state and take effect the next cycle.
  - Writes to addr 4 clear err and/or timeout where wdata[2]/wdata[4] is 1; other bits are ignored.
  - Writes to addr 5..7 are ignored.
- FSM states IDLE, CHECK, ARMED, MUTE:
  - IDLE: commit, or a commit latched in pending_commit -> CHECK. Shadow is copied into the staged registers on this edge.
  - CHECK (one cycle). The staged set is valid only if all of the following hold:
    - start_x < end_x <= H_DISP
    - start_y < end_y <= V_DISP
    - 1 <= out_x_res <= H_DISP and 1 <= out_y_res <= V_DISP
    - If valid -> ARMED. If invalid -> IDLE with err=1; active registers are unchanged.
  - ARMED:
    - On vs_rise, staged is loaded into active (visible next cycle).
    - If the mode changed -> MUTE with mute=1 and the frame counter cleared; else -> IDLE.
    - vs_rise in the same cycle as entering ARMED counts, but only if ARMED is already the current state. A commit coinciding with vs_rise waits for the following vs_rise.
  - ARMED with a new commit: recopy shadow and return to CHECK (last commit wins). The old staged set is discarded even if the new set is invalid.
  - MUTE:
    - Count vs_rise events; after MUTE_FRAMES of them, clear mute on the same edge and go to IDLE.
    - A commit during MUTE sets pending_commit, which is consumed in IDLE.
- Arithmetic: *_m1 values are modulo field width; they are registered and update with the active registers, with no extra latency.
- busy = (state != IDLE) or pending_commit. armed = (state == ARMED).
- rst asserted mid-operation restores all reset values on the next edge, discarding staged and pending state.

Optional Feature:
- Macro: VP_CFG_TIMEOUT_EN.
- Defined: a counter runs in ARMED. If TIMEOUT_CYC cycles elapse with no vs_rise, the staged set is applied as on a vs_rise and timeout=1.
- Undefined: ARMED waits indefinitely; status[4] reads 0.

Decomposition:
- Package vp_cfg_pkg holds:
  - address constants (ADDR_CR..ADDR_STATUS) and mode encodings;
  - the FSM state enum;
  - field bit positions (mode [31:30], Y at 16) and status bit indices.
- Sub-module vp_cfg_check: combinational validator taking the staged fields plus H_DISP/V_DISP and returning valid. It is reused by software-model checks.

Test Plan:
- Reset -> act_mode=11, end_x=1280, end_y=720, in_x_res_m1=1279, filler_en=0, status=0.
- Setup: START=0x0000_0180, END=0x0168_0300, SCALER=0x02D0_0500, CR=0x0000_0000, then commit.
  - No output change before vs_rise.
  - One cycle after vs_rise: start_x=384, in_x_res_m1=383, in_y_res_m1=359, out_x_res_m1=1279, act_mode=00, filler_en=0.
  - mute=1 for exactly 2 vs_rise events.
- END_X=100 with START_X=384, then commit -> err=1 two cycles later, active unchanged. Write STATUS 0x4 -> err=0.
- Two valid commits (SCALER 0x0168_0280, then 0x02D0_0500) before vs_rise -> active out_x_res=1280, and filler_en matches the second set.
- Commit in the same cycle as vs_rise -> applied only at the next vs_rise. Commit during MUTE -> applied at the first vs_rise after MUTE ends.
- With VP_CFG_TIMEOUT_EN and TIMEOUT_CYC=64, commit with vs_in held low -> active updates after 64 ARMED cycles and status[4]=1.

Source files
------------

// File: rtl/vp_cfg_pkg.sv
// Shared constants for the video-process configuration sequencer:
// register addresses, mode encodings, FSM states and field positions.
package vp_cfg_pkg;

  localparam logic [2:0] ADDR_CR     = 3'd0;
  localparam logic [2:0] ADDR_START  = 3'd1;
  localparam logic [2:0] ADDR_END    = 3'd2;
  localparam logic [2:0] ADDR_SCALER = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  localparam logic [1:0] MODE_SCALER = 2'b00;
  localparam logic [1:0] MODE_EDGE   = 2'b01;
  localparam logic [1:0] MODE_BIN    = 2'b10;
  localparam logic [1:0] MODE_BYPASS = 2'b11;

  localparam int MODE_HI = 31;
  localparam int MODE_LO = 30;
  localparam int Y_LSB   = 16;

  localparam int ST_BUSY     = 0;
  localparam int ST_ARMED    = 1;
  localparam int ST_ERR      = 2;
  localparam int ST_MUTE     = 3;
  localparam int ST_TIMEOUT  = 4;
  localparam int ST_FCNT_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ARMED = 2'd2,
    S_MUTE  = 2'd3
  } state_t;

endpackage

// File: rtl/vp_cfg_check.sv
// Combinational validator for a staged crop/scale configuration set.
module vp_cfg_check #(
  parameter int XW     = 11,
  parameter int YW     = 11,
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720
) (
  input  logic [XW-1:0] start_x,
  input  logic [XW-1:0] end_x,
  input  logic [XW-1:0] out_x_res,
  input  logic [YW-1:0] start_y,
  input  logic [YW-1:0] end_y,
  input  logic [YW-1:0] out_y_res,
  output logic          valid
);

  assign valid = (start_x < end_x) && (end_x <= XW'(H_DISP)) &&
                 (start_y < end_y) && (end_y <= YW'(V_DISP)) &&
                 (out_x_res != {XW{1'b0}}) && (out_x_res <= XW'(H_DISP)) &&
                 (out_y_res != {YW{1'b0}}) && (out_y_res <= YW'(V_DISP));

endmodule

// File: rtl/vp_cfg_sequencer.sv
// Shadow/staged/active configuration sequencer with frame-aligned apply and mute window.
// Optional ARMED timeout enabled by defining VP_CFG_TIMEOUT_EN.
module vp_cfg_sequencer
  import vp_cfg_pkg::*;
#(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int XW          = 11,
  parameter int YW          = 11,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int MUTE_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic          commit,
  input  logic          vs_in,
  output logic [1:0]    act_mode,
  output logic [XW-1:0] start_x,
  output logic [XW-1:0] end_x,
  output logic [XW-1:0] out_x_res,
  output logic [YW-1:0] start_y,
  output logic [YW-1:0] end_y,
  output logic [YW-1:0] out_y_res,
  output logic [XW-1:0] in_x_res_m1,
  output logic [XW-1:0] out_x_res_m1,
  output logic [YW-1:0] in_y_res_m1,
  output logic [YW-1:0] out_y_res_m1,
  output logic          filler_en,
  output logic          mute,
  output logic [31:0]   status
);

  state_t        state;
  logic          vs_d, vs_rise, pending, err, timeout, to_fire, stage_valid;
  logic [15:0]   frame_cnt;
  logic [3:0]    mute_cnt;
  logic [1:0]    sh_mode, st_mode;
  logic [XW-1:0] sh_sx, sh_ex, sh_ox, st_sx, st_ex, st_ox;
  logic [YW-1:0] sh_sy, sh_ey, sh_oy, st_sy, st_ey, st_oy;
  logic          unused_wdata;

  assign unused_wdata = ^cfg_wdata;
  assign vs_rise      = vs_in & ~vs_d;
  assign status       = {frame_cnt, 11'd0, timeout, mute, err,
                         (state == S_ARMED), (state != S_IDLE) | pending};

  vp_cfg_check #(.XW(XW), .YW(YW), .H_DISP(H_DISP), .V_DISP(V_DISP)) u_check (
    .start_x  (st_sx),
    .end_x    (st_ex),
    .out_x_res(st_ox),
    .start_y  (st_sy),
    .end_y    (st_ey),
    .out_y_res(st_oy),
    .valid    (stage_valid)
  );

`ifdef VP_CFG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] to_cnt;

  assign to_fire = (state == S_ARMED) && !vs_rise && (to_cnt == TW'(TIMEOUT_CYC - 1));

  // ARMED-cycle counter, restarted by any frame start or state exit
  always_ff @(posedge clk) begin
    if (rst || state != S_ARMED || vs_rise) begin
      to_cnt <= {TW{1'b0}};
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Shadow writes, frame counting and the commit/apply state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      vs_d         <= 1'b0;
      pending      <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
      frame_cnt    <= 16'd0;
      mute_cnt     <= 4'd0;
      mute         <= 1'b0;
      sh_mode      <= MODE_BYPASS;
      sh_sx        <= {XW{1'b0}};
      sh_ex        <= XW'(H_DISP);
      sh_ox        <= XW'(H_DISP);
      sh_sy        <= {YW{1'b0}};
      sh_ey        <= YW'(V_DISP);
      sh_oy        <= YW'(V_DISP);
      st_mode      <= MODE_BYPASS;
      st_sx        <= {XW{1'b0}};
      st_ex        <= XW'(H_DISP);
      st_ox        <= XW'(H_DISP);
      st_sy        <= {YW{1'b0}};
      st_ey        <= YW'(V_DISP);
      st_oy        <= YW'(V_DISP);
      act_mode     <= MODE_BYPASS;
      start_x      <= {XW{1'b0}};
      end_x        <= XW'(H_DISP);
      out_x_res    <= XW'(H_DISP);
      start_y      <= {YW{1'b0}};
      end_y        <= YW'(V_DISP);
      out_y_res    <= YW'(V_DISP);
      in_x_res_m1  <= XW'(H_DISP - 1);
      out_x_res_m1 <= XW'(H_DISP - 1);
      in_y_res_m1  <= YW'(V_DISP - 1);
      out_y_res_m1 <= YW'(V_DISP - 1);
      filler_en    <= 1'b0;
    end else begin
      vs_d <= vs_in;
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (cfg_wr) begin
        case (cfg_addr)
          ADDR_CR:     sh_mode <= cfg_wdata[MODE_HI:MODE_LO];
          ADDR_START:  begin sh_sx <= cfg_wdata[XW-1:0]; sh_sy <= cfg_wdata[Y_LSB +: YW]; end
          ADDR_END:    begin sh_ex <= cfg_wdata[XW-1:0]; sh_ey <= cfg_wdata[Y_LSB +: YW]; end
          ADDR_SCALER: begin sh_ox <= cfg_wdata[XW-1:0]; sh_oy <= cfg_wdata[Y_LSB +: YW]; end
          ADDR_STATUS: begin
            if (cfg_wdata[ST_ERR]) err <= 1'b0;
            if (cfg_wdata[ST_TIMEOUT]) timeout <= 1'b0;
          end
          default: ;
        endcase
      end
      case (state)
        S_IDLE: begin
          if (commit || pending) begin
            {st_mode, st_sx, st_ex, st_ox} <= {sh_mode, sh_sx, sh_ex, sh_ox};
            {st_sy, st_ey, st_oy}          <= {sh_sy, sh_ey, sh_oy};
            pending <= 1'b0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (commit) pending <= 1'b1;
          if (stage_valid) begin
            state <= S_ARMED;
          end else begin
            state <= S_IDLE;
            err   <= 1'b1;
          end
        end
        S_ARMED: begin
          // A fresh commit supersedes the staged set, even on a frame start
          if (commit) begin
            {st_mode, st_sx, st_ex, st_ox} <= {sh_mode, sh_sx, sh_ex, sh_ox};
            {st_sy, st_ey, st_oy}          <= {sh_sy, sh_ey, sh_oy};
            state <= S_CHECK;
          end else if (vs_rise || to_fire) begin
            act_mode     <= st_mode;
            start_x      <= st_sx;
            end_x        <= st_ex;
            out_x_res    <= st_ox;
            start_y      <= st_sy;
            end_y        <= st_ey;
            out_y_res    <= st_oy;
            in_x_res_m1  <= st_ex - st_sx - XW'(1);
            out_x_res_m1 <= st_ox - XW'(1);
            in_y_res_m1  <= st_ey - st_sy - YW'(1);
            out_y_res_m1 <= st_oy - YW'(1);
            filler_en    <= (st_mode == MODE_SCALER) && (st_ox < XW'(H_DISP));
            if (to_fire) timeout <= 1'b1;
            if (st_mode != act_mode) begin
              state     <= S_MUTE;
              mute      <= 1'b1;
              mute_cnt  <= 4'd0;
              frame_cnt <= 16'd0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_MUTE: begin
          if (commit) pending <= 1'b1;
          if (vs_rise) begin
            if (mute_cnt == 4'(MUTE_FRAMES - 1)) begin
              mute  <= 1'b0;
              state <= S_IDLE;
            end else begin
              mute_cnt <= mute_cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vp_cfg_sequencer.sv
// Directed self-checking bench for vp_cfg_sequencer (VP_CFG_TIMEOUT_EN adds the timeout case).
module tb_vp_cfg_sequencer;

`ifdef VP_CFG_TIMEOUT_EN
  localparam int TO_CYC = 64;
`else
  localparam int TO_CYC = 1048576;
`endif

  logic        clk = 1'b0;
  logic        rst, cfg_wr, commit, vs_in;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata, status;
  logic [1:0]  act_mode;
  logic [10:0] start_x, end_x, out_x_res, in_x_res_m1, out_x_res_m1;
  logic [10:0] start_y, end_y, out_y_res, in_y_res_m1, out_y_res_m1;
  logic        filler_en, mute;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vp_cfg_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .commit(commit), .vs_in(vs_in), .act_mode(act_mode),
    .start_x(start_x), .end_x(end_x), .out_x_res(out_x_res),
    .start_y(start_y), .end_y(end_y), .out_y_res(out_y_res),
    .in_x_res_m1(in_x_res_m1), .out_x_res_m1(out_x_res_m1),
    .in_y_res_m1(in_y_res_m1), .out_y_res_m1(out_y_res_m1),
    .filler_en(filler_en), .mute(mute), .status(status)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0; commit = 1'b0; vs_in = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_mode", 32'(act_mode), 32'd3);
    chk("rst_end_x", 32'(end_x), 32'd1280);
    chk("rst_end_y", 32'(end_y), 32'd720);
    chk("rst_in_x_m1", 32'(in_x_res_m1), 32'd1279);
    chk("rst_out_y_m1", 32'(out_y_res_m1), 32'd719);
    chk("rst_filler", 32'(filler_en), 32'd0);
    chk("rst_mute", 32'(mute), 32'd0);
    chk("rst_status", status, 32'd0);

    // Scaler-mode crop set, applied on the next frame start
    wr(3'd1, 32'h0000_0180);
    wr(3'd2, 32'h0168_0300);
    wr(3'd3, 32'h02D0_0500);
    wr(3'd0, 32'h0000_0000);
    do_commit();
    chk("check_busy", status, 32'h0000_0001);
    step();
    chk("armed_status", status, 32'h0000_0003);
    step(); step();
    chk("pre_vs_start_x", 32'(start_x), 32'd0);
    chk("pre_vs_mode", 32'(act_mode), 32'd3);
    vs_in = 1'b1; step();
    chk("apply_start_x", 32'(start_x), 32'd384);
    chk("apply_in_x_m1", 32'(in_x_res_m1), 32'd383);
    chk("apply_in_y_m1", 32'(in_y_res_m1), 32'd359);
    chk("apply_out_x_m1", 32'(out_x_res_m1), 32'd1279);
    chk("apply_mode", 32'(act_mode), 32'd0);
    chk("apply_filler", 32'(filler_en), 32'd0);
    chk("apply_mute", 32'(mute), 32'd1);
    chk("apply_status", status, 32'h0000_0009);
    vs_in = 1'b0; step();
    vs_in = 1'b1; step();
    chk("mute_after_1", 32'(mute), 32'd1);
    chk("fcnt_after_1", status, 32'h0001_0009);
    vs_in = 1'b0; step();
    vs_in = 1'b1; step();
    chk("mute_after_2", 32'(mute), 32'd0);
    chk("status_after_mute", status, 32'h0002_0000);
    vs_in = 1'b0; step();

    // Invalid window: end_x below start_x
    wr(3'd2, 32'h0168_0064);
    do_commit();
    chk("err_not_yet", 32'(status[2]), 32'd0);
    step();
    chk("err_set", status, 32'h0002_0004);
    chk("err_end_x_kept", 32'(end_x), 32'd768);
    wr(3'd4, 32'h0000_0004);
    chk("err_cleared", status, 32'h0002_0000);

    // Reduced output width enables the filler
    wr(3'd2, 32'h0168_0300);
    wr(3'd3, 32'h0168_0280);
    do_commit(); step();
    vs_in = 1'b1; step();
    chk("narrow_out_x", 32'(out_x_res), 32'd640);
    chk("narrow_out_x_m1", 32'(out_x_res_m1), 32'd639);
    chk("narrow_filler", 32'(filler_en), 32'd1);
    chk("narrow_no_mute", 32'(mute), 32'd0);
    vs_in = 1'b0; step();

    // Two commits before a frame start: the later one wins
    wr(3'd3, 32'h0168_0280);
    do_commit(); step();
    wr(3'd3, 32'h02D0_0500);
    do_commit(); step();
    chk("recommit_armed", status, 32'h0003_0003);
    vs_in = 1'b1; step();
    chk("last_wins_out_x", 32'(out_x_res), 32'd1280);
    chk("last_wins_out_y", 32'(out_y_res), 32'd720);
    chk("last_wins_filler", 32'(filler_en), 32'd0);
    vs_in = 1'b0; step();

    // Commit together with a frame start waits for the following one
    wr(3'd0, 32'h4000_0000);
    commit = 1'b1; vs_in = 1'b1; step();
    commit = 1'b0; vs_in = 1'b0; step();
    chk("coincide_not_applied", 32'(act_mode), 32'd0);
    chk("coincide_armed", status, 32'h0005_0003);
    vs_in = 1'b1; step();
    chk("coincide_applied", 32'(act_mode), 32'd1);
    chk("coincide_mute", status, 32'h0000_0009);
    vs_in = 1'b0; step();

    // Commit during mute is held until the window closes
    wr(3'd1, 32'h0000_0000);
    do_commit();
    chk("mute_pending_busy", status, 32'h0000_0009);
    vs_in = 1'b1; step();
    vs_in = 1'b0; step();
    vs_in = 1'b1; step();
    chk("mute_end", 32'(mute), 32'd0);
    chk("mute_end_start_x", 32'(start_x), 32'd384);
    vs_in = 1'b0; step();
    step();
    chk("pending_armed", status, 32'h0002_0003);
    vs_in = 1'b1; step();
    chk("pending_start_x", 32'(start_x), 32'd0);
    chk("pending_in_x_m1", 32'(in_x_res_m1), 32'd767);
    chk("pending_status", status, 32'h0003_0000);
    vs_in = 1'b0; step();

`ifdef VP_CFG_TIMEOUT_EN
    // No frame start: staged set applies after 64 armed cycles
    wr(3'd1, 32'h0000_0010);
    do_commit(); step();
    repeat (63) step();
    chk("to_not_yet", 32'(start_x), 32'd0);
    step();
    chk("to_applied", 32'(start_x), 32'd16);
    chk("to_flag", 32'(status[4]), 32'd1);
    wr(3'd4, 32'h0000_0010);
    chk("to_cleared", 32'(status[4]), 32'd0);
`endif

    // Reset in mid-operation
    wr(3'd3, 32'h0168_0280);
    do_commit();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst2_status", status, 32'd0);
    chk("rst2_mode", 32'(act_mode), 32'd3);
    chk("rst2_start_x", 32'(start_x), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
